// File: rtl/lap_memory_if.sv
// Bus between the lap buffer and its neighbours: the live BCD counter and the
// pulse stages on one side, the 7-segment multiplexer on the other.
interface lap_memory_if;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       rec_pulse;
  logic       next_pulse;
  logic       clear_pulse;
  logic [3:0] view_tens;
  logic [3:0] view_ones;
  logic [2:0] view_idx;
  logic       browsing;
  logic [3:0] count;
  logic       full;
  logic       empty;

  modport master (
    output cnt_tens, cnt_ones, rec_pulse, next_pulse, clear_pulse,
    input  view_tens, view_ones, view_idx, browsing, count, full, empty
  );

  modport slave (
    input  cnt_tens, cnt_ones, rec_pulse, next_pulse, clear_pulse,
    output view_tens, view_ones, view_idx, browsing, count, full, empty
  );
endinterface

// File: rtl/lap_memory.sv
// Ring buffer of recorded laps with a browse mode that steps from newest to
// oldest and drops back to the live (newest) view after a period of inactivity.
module lap_memory #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 24
) (
  input  logic         clk_div23,
  input  logic         reset,
  lap_memory_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {LIVE, BROWSE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d, rdPtr;
  logic [3:0]      count_q, count_d;
  logic [2:0]      viewIdx_q, viewIdx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      view_q, view_d;
  logic            memWe;
  logic            isFull;

  assign isFull = (count_q == 4'(DEPTH));

  always_comb begin
    state_d   = state_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    viewIdx_d = viewIdx_q;
    timer_d   = timer_q;
    memWe     = 1'b0;
    rdPtr     = '0;
    view_d    = view_q;

    if (bus.clear_pulse) begin
      state_d   = LIVE;
      wrPtr_d   = '0;
      count_d   = '0;
      viewIdx_d = '0;
      timer_d   = '0;
    end else if (bus.rec_pulse) begin
      memWe     = 1'b1;
      wrPtr_d   = wrPtr_q + PW'(1);
      count_d   = isFull ? count_q : count_q + 4'd1;
      state_d   = LIVE;
      viewIdx_d = '0;
      timer_d   = '0;
    end else if (bus.next_pulse) begin
      if (state_q == LIVE) begin
        if (count_q >= 4'd2) begin
          state_d   = BROWSE;
          viewIdx_d = 3'd1;
          timer_d   = '0;
        end
      end else if ({1'b0, viewIdx_q} < count_q - 4'd1) begin
        viewIdx_d = viewIdx_q + 3'd1;
        timer_d   = '0;
      end else begin
        state_d   = LIVE;
        viewIdx_d = '0;
        timer_d   = '0;
      end
    end else if (state_q == BROWSE) begin
      if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d   = LIVE;
        viewIdx_d = '0;
        timer_d   = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    // The memory is only written on a record, which bypasses it straight to the view.
    rdPtr = wrPtr_q - PW'(1) - PW'(viewIdx_d);
    if (bus.clear_pulse) begin
      view_d = '0;
    end else if (bus.rec_pulse) begin
      view_d = {bus.cnt_tens, bus.cnt_ones};
    end else if (count_q == 4'd0) begin
      view_d = '0;
    end else begin
      view_d = mem_q[rdPtr];
    end
  end

  always_ff @(posedge clk_div23) begin
    if (reset) begin
      state_q   <= LIVE;
      wrPtr_q   <= '0;
      count_q   <= '0;
      viewIdx_q <= '0;
      timer_q   <= '0;
      view_q    <= '0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      viewIdx_q <= viewIdx_d;
      timer_q   <= timer_d;
      view_q    <= view_d;
    end
  end

  always_ff @(posedge clk_div23) begin
    if (!reset && memWe) begin
      mem_q[wrPtr_q] <= {bus.cnt_tens, bus.cnt_ones};
    end
  end

  assign bus.view_tens = view_q[7:4];
  assign bus.view_ones = view_q[3:0];
  assign bus.view_idx  = viewIdx_q;
  assign bus.browsing  = (state_q == BROWSE);
  assign bus.count     = count_q;
  assign bus.full      = isFull;
  assign bus.empty     = (count_q == 4'd0);

endmodule

// File: tb/tb_lap_memory.sv
// Directed test of lap_memory with DEPTH=4, TIMEOUT=24 and hand-computed expectations.
module tb_lap_memory;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 24;

  logic clk_div23 = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  lap_memory_if bus ();

  lap_memory #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_div23 (clk_div23),
    .reset     (reset),
    .bus       (bus.slave)
  );

  always #5 clk_div23 = ~clk_div23;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rec, input logic nxt, input logic clr,
                               input logic [3:0] tens, input logic [3:0] ones);
    @(negedge clk_div23);
    bus.rec_pulse   = rec;
    bus.next_pulse  = nxt;
    bus.clear_pulse = clr;
    bus.cnt_tens    = tens;
    bus.cnt_ones    = ones;
    @(posedge clk_div23);
    #1;
    bus.rec_pulse   = 1'b0;
    bus.next_pulse  = 1'b0;
    bus.clear_pulse = 1'b0;
  endtask

  task automatic record(input logic [3:0] tens, input logic [3:0] ones);
    applyStimulus(1'b1, 1'b0, 1'b0, tens, ones);
  endtask

  task automatic stepNext();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd9, 4'd9);
  endtask

  task automatic clearAll();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'(i % 10), 4'((i + 3) % 10));
  endtask

  task automatic checkView(input string tag, input logic [3:0] tens, input logic [3:0] ones,
                           input logic [2:0] idx, input logic br, input logic [3:0] cnt);
    checkOutput($sformatf("%s.tens", tag),     {4'd0, bus.view_tens}, {4'd0, tens});
    checkOutput($sformatf("%s.ones", tag),     {4'd0, bus.view_ones}, {4'd0, ones});
    checkOutput($sformatf("%s.idx", tag),      {5'd0, bus.view_idx},  {5'd0, idx});
    checkOutput($sformatf("%s.browsing", tag), {7'd0, bus.browsing},  {7'd0, br});
    checkOutput($sformatf("%s.count", tag),    {4'd0, bus.count},     {4'd0, cnt});
    checkOutput($sformatf("%s.full", tag),     {7'd0, bus.full},      {7'd0, (cnt == 4'd4)});
    checkOutput($sformatf("%s.empty", tag),    {7'd0, bus.empty},     {7'd0, (cnt == 4'd0)});
  endtask

  initial begin
    reset           = 1'b1;
    bus.rec_pulse   = 1'b0;
    bus.next_pulse  = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.cnt_tens    = 4'd0;
    bus.cnt_ones    = 4'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkView("reset", 4'd0, 4'd0, 3'd0, 1'b0, 4'd0);
    @(negedge clk_div23);
    reset = 1'b0;

    idle(10);
    checkView("idle", 4'd0, 4'd0, 3'd0, 1'b0, 4'd0);
    stepNext();
    checkView("nextEmpty", 4'd0, 4'd0, 3'd0, 1'b0, 4'd0);

    record(4'd1, 4'd2);
    checkView("rec1", 4'd1, 4'd2, 3'd0, 1'b0, 4'd1);
    stepNext();
    checkView("nextOne", 4'd1, 4'd2, 3'd0, 1'b0, 4'd1);

    clearAll();
    checkView("clear1", 4'd0, 4'd0, 3'd0, 1'b0, 4'd0);
    record(4'd1, 4'd2);
    record(4'd3, 4'd4);
    record(4'd5, 4'd6);
    checkView("rec3", 4'd5, 4'd6, 3'd0, 1'b0, 4'd3);
    idle(3);
    checkView("liveIgnored", 4'd5, 4'd6, 3'd0, 1'b0, 4'd3);
    stepNext();
    checkView("browse1", 4'd3, 4'd4, 3'd1, 1'b1, 4'd3);
    stepNext();
    checkView("browse2", 4'd1, 4'd2, 3'd2, 1'b1, 4'd3);
    stepNext();
    checkView("browseWrap", 4'd5, 4'd6, 3'd0, 1'b0, 4'd3);

    clearAll();
    record(4'd1, 4'd1);
    record(4'd2, 4'd2);
    record(4'd3, 4'd3);
    record(4'd4, 4'd4);
    checkView("fill4", 4'd4, 4'd4, 3'd0, 1'b0, 4'd4);
    record(4'd5, 4'd5);
    checkView("overwrite", 4'd5, 4'd5, 3'd0, 1'b0, 4'd4);
    stepNext();
    checkView("fullB1", 4'd4, 4'd4, 3'd1, 1'b1, 4'd4);
    stepNext();
    checkView("fullB2", 4'd3, 4'd3, 3'd2, 1'b1, 4'd4);
    stepNext();
    checkView("fullB3", 4'd2, 4'd2, 3'd3, 1'b1, 4'd4);
    stepNext();
    checkView("fullWrap", 4'd5, 4'd5, 3'd0, 1'b0, 4'd4);

    stepNext();
    checkView("toB1", 4'd4, 4'd4, 3'd1, 1'b1, 4'd4);
    idle(TIMEOUT - 1);
    checkView("timeoutPre", 4'd4, 4'd4, 3'd1, 1'b1, 4'd4);
    idle(1);
    checkView("timeoutHit", 4'd5, 4'd5, 3'd0, 1'b0, 4'd4);

    stepNext();
    checkView("reB1", 4'd4, 4'd4, 3'd1, 1'b1, 4'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd7, 4'd8);
    checkView("recNext", 4'd7, 4'd8, 3'd0, 1'b0, 4'd4);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd6, 4'd6);
    checkView("clearRec", 4'd0, 4'd0, 3'd0, 1'b0, 4'd0);

    record(4'd1, 4'd1);
    record(4'd2, 4'd2);
    stepNext();
    checkView("preReset", 4'd1, 4'd1, 3'd1, 1'b1, 4'd2);
    @(negedge clk_div23);
    reset = 1'b1;
    @(posedge clk_div23);
    #1;
    checkView("midReset", 4'd0, 4'd0, 3'd0, 1'b0, 4'd0);
    @(negedge clk_div23);
    reset = 1'b0;

    record(4'hF, 4'hA);
    checkView("nonBcd", 4'hF, 4'hA, 3'd0, 1'b0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
